// File: rtl/voice_allocator_pkg.sv
// Shared MIDI definitions for the voice allocator: command record and FSM states.
package voice_allocator_pkg;

  localparam int unsigned NOTE_WIDTH = 7;

  typedef struct packed {
    logic                  valid;
    logic                  on;
    logic [NOTE_WIDTH-1:0] note;
    logic [NOTE_WIDTH-1:0] velocity;
  } voice_command_t;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StIssue,
    StRelease
  } alloc_state_e;

endpackage

// File: rtl/voice_age_counter.sv
// Saturating per-voice age counter; cleared when a voice is (re)triggered.
module voice_age_counter #(
  parameter int unsigned AGE_WIDTH = 8
) (
  input  logic                 clock_50_000_000,
  input  logic                 reset_l,
  input  logic                 clear,
  input  logic                 increment,
  output logic [AGE_WIDTH-1:0] age
);

  // Clear has priority; increment stops at all-ones.
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      age <= '0;
    end else if (clear) begin
      age <= '0;
    end else if (increment && (age != '1)) begin
      age <= age + 1'b1;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans voices one per cycle, then retriggers,
// allocates, steals or releases a voice; sustain-pedal release is batched.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int unsigned PIPELINE_COUNT = 4,
  parameter int unsigned AGE_WIDTH      = 8
) (
  input  logic                                       clock_50_000_000,
  input  logic                                       reset_l,
  input  logic                                       event_valid,
  output logic                                       event_ready,
  input  logic                                       event_on,
  input  logic [NOTE_WIDTH-1:0]                      event_note,
  input  logic [NOTE_WIDTH-1:0]                      event_velocity,
  input  logic                                       sustain,
  output logic [PIPELINE_COUNT-1:0]                  voice_valid,
  output logic [PIPELINE_COUNT-1:0]                  voice_on,
  output logic [PIPELINE_COUNT-1:0][NOTE_WIDTH-1:0]  voice_note,
  output logic [PIPELINE_COUNT-1:0][NOTE_WIDTH-1:0]  voice_velocity,
  output logic [PIPELINE_COUNT-1:0]                  voice_busy
);

  localparam int unsigned IDX_W = (PIPELINE_COUNT > 1) ? $clog2(PIPELINE_COUNT) : 1;
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(PIPELINE_COUNT - 1);

  alloc_state_e state_q, state_d;
  logic         accept;

  logic                  ev_on_q;
  logic [NOTE_WIDTH-1:0] ev_note_q, ev_vel_q;

  idx_t                 scan_idx_q;
  logic                 match_found_q, free_found_q, old_found_q;
  idx_t                 match_idx_q, free_idx_q, old_idx_q;
  logic [AGE_WIDTH-1:0] old_age_q;

  logic sustain_q, release_pending_q;

  voice_command_t [PIPELINE_COUNT-1:0] cmd_q, cmd_d;
  logic [PIPELINE_COUNT-1:0]           busy_q, busy_d, sustained_q, sustained_d;
  logic [PIPELINE_COUNT-1:0]           age_clear, age_inc;
  logic [PIPELINE_COUNT-1:0][AGE_WIDTH-1:0] age;

  logic                  cur_busy;
  logic [NOTE_WIDTH-1:0] cur_note;
  logic [AGE_WIDTH-1:0]  cur_age;
  idx_t                  target;

  for (genvar g = 0; g < PIPELINE_COUNT; g++) begin : g_age
    voice_age_counter #(
      .AGE_WIDTH(AGE_WIDTH)
    ) u_age (
      .clock_50_000_000(clock_50_000_000),
      .reset_l         (reset_l),
      .clear           (age_clear[g]),
      .increment       (age_inc[g]),
      .age             (age[g])
    );
  end

  // FSM state register.
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // FSM next state and handshake; a pending release always wins over a new event.
  always_comb begin
    state_d     = state_q;
    event_ready = 1'b0;
    accept      = 1'b0;
    case (state_q)
      StIdle: begin
        if (release_pending_q) begin
          state_d = StRelease;
        end else begin
          event_ready = 1'b1;
          if (event_valid) begin
            accept  = 1'b1;
            state_d = StScan;
          end
        end
      end
      StScan:    if (scan_idx_q == LAST_IDX) state_d = StIssue;
      StIssue:   state_d = StIdle;
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Voice currently under examination.
  always_comb begin
    cur_busy = busy_q[scan_idx_q];
    cur_note = cmd_q[scan_idx_q].note;
    cur_age  = age[scan_idx_q];
    target   = match_found_q ? match_idx_q : (free_found_q ? free_idx_q : old_idx_q);
  end

  // Event capture and per-voice scan bookkeeping.
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      ev_on_q       <= 1'b0;
      ev_note_q     <= '0;
      ev_vel_q      <= '0;
      scan_idx_q    <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
    end else if (accept) begin
      // Velocity-zero note-on is a note-off in MIDI.
      ev_on_q       <= event_on && (event_velocity != '0);
      ev_note_q     <= event_note;
      ev_vel_q      <= event_velocity;
      scan_idx_q    <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
    end else if (state_q == StScan) begin
      scan_idx_q <= scan_idx_q + 1'b1;
      if (cur_busy && (cur_note == ev_note_q) && !match_found_q) begin
        match_found_q <= 1'b1;
        match_idx_q   <= scan_idx_q;
      end
      if (!cur_busy && !free_found_q) begin
        free_found_q <= 1'b1;
        free_idx_q   <= scan_idx_q;
      end
      // Strict compare keeps the lowest index on ties.
      if (cur_busy && (!old_found_q || (cur_age > old_age_q))) begin
        old_found_q <= 1'b1;
        old_idx_q   <= scan_idx_q;
        old_age_q   <= cur_age;
      end
    end
  end

  // Sustain falling-edge detect; pending survives until RELEASE services it.
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      sustain_q         <= 1'b0;
      release_pending_q <= 1'b0;
    end else begin
      sustain_q <= sustain;
      if (sustain_q && !sustain)      release_pending_q <= 1'b1;
      else if (state_q == StRelease)  release_pending_q <= 1'b0;
    end
  end

  // Per-voice command, busy/sustain and age updates for ISSUE and RELEASE.
  always_comb begin
    cmd_d       = cmd_q;
    busy_d      = busy_q;
    sustained_d = sustained_q;
    age_clear   = '0;
    age_inc     = '0;
    for (int i = 0; i < PIPELINE_COUNT; i++) begin
      cmd_d[i].valid = 1'b0;
      cmd_d[i].on    = 1'b0;
    end
    if (state_q == StIssue) begin
      for (int i = 0; i < PIPELINE_COUNT; i++) begin
        if (ev_on_q) begin
          if (idx_t'(i) == target) begin
            cmd_d[i].valid    = 1'b1;
            cmd_d[i].on       = 1'b1;
            cmd_d[i].note     = ev_note_q;
            cmd_d[i].velocity = ev_vel_q;
            busy_d[i]         = 1'b1;
            sustained_d[i]    = 1'b0;
            age_clear[i]      = 1'b1;
          end else if (busy_q[i]) begin
            age_inc[i] = 1'b1;
          end
        end else if (match_found_q && (idx_t'(i) == match_idx_q)) begin
          if (sustain) begin
            sustained_d[i] = 1'b1;
          end else begin
            cmd_d[i].valid = 1'b1;
            busy_d[i]      = 1'b0;
            sustained_d[i] = 1'b0;
          end
        end
      end
    end else if (state_q == StRelease) begin
      for (int i = 0; i < PIPELINE_COUNT; i++) begin
        if (sustained_q[i]) begin
          cmd_d[i].valid = 1'b1;
          busy_d[i]      = 1'b0;
          sustained_d[i] = 1'b0;
        end
      end
    end
  end

  // Voice command and status registers.
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      cmd_q       <= '0;
      busy_q      <= '0;
      sustained_q <= '0;
    end else begin
      cmd_q       <= cmd_d;
      busy_q      <= busy_d;
      sustained_q <= sustained_d;
    end
  end

  // Unpack command records onto the output ports.
  always_comb begin
    for (int i = 0; i < PIPELINE_COUNT; i++) begin
      voice_valid[i]    = cmd_q[i].valid;
      voice_on[i]       = cmd_q[i].on;
      voice_note[i]     = cmd_q[i].note;
      voice_velocity[i] = cmd_q[i].velocity;
    end
    voice_busy = busy_q;
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator with four voices.
module tb_voice_allocator;

  logic            clock_50_000_000 = 1'b0;
  logic            reset_l          = 1'b0;
  logic            event_valid      = 1'b0;
  logic            event_ready;
  logic            event_on         = 1'b0;
  logic [6:0]      event_note       = '0;
  logic [6:0]      event_velocity   = '0;
  logic            sustain          = 1'b0;
  logic [3:0]      voice_valid;
  logic [3:0]      voice_on;
  logic [3:0][6:0] voice_note;
  logic [3:0][6:0] voice_velocity;
  logic [3:0]      voice_busy;

  int checks = 0;
  int fails  = 0;

  int         strobe_cycle;
  logic [3:0] strobe_valid;
  logic [3:0] strobe_on;
  logic       ready_at_end;

  voice_allocator #(
    .PIPELINE_COUNT(4),
    .AGE_WIDTH     (8)
  ) dut (
    .clock_50_000_000(clock_50_000_000),
    .reset_l         (reset_l),
    .event_valid     (event_valid),
    .event_ready     (event_ready),
    .event_on        (event_on),
    .event_note      (event_note),
    .event_velocity  (event_velocity),
    .sustain         (sustain),
    .voice_valid     (voice_valid),
    .voice_on        (voice_on),
    .voice_note      (voice_note),
    .voice_velocity  (voice_velocity),
    .voice_busy      (voice_busy)
  );

  always #10 clock_50_000_000 = ~clock_50_000_000;

  task automatic apply_reset();
    reset_l     = 1'b0;
    event_valid = 1'b0;
    sustain     = 1'b0;
    repeat (2) @(posedge clock_50_000_000);
    @(negedge clock_50_000_000);
    reset_l = 1'b1;
  endtask

  // Offers one event, then watches six cycles after acceptance for the first strobe.
  task automatic send_event(input logic on, input logic [6:0] note, input logic [6:0] vel);
    int waited = 0;
    @(negedge clock_50_000_000);
    while (!event_ready && waited < 20) begin
      @(negedge clock_50_000_000);
      waited++;
    end
    checks++;
    if (event_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_timeout: event_ready=%b required 1", event_ready);
    end
    event_valid    = 1'b1;
    event_on       = on;
    event_note     = note;
    event_velocity = vel;
    @(posedge clock_50_000_000);
    #1 event_valid = 1'b0;
    strobe_cycle = 0;
    strobe_valid = '0;
    strobe_on    = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock_50_000_000);
      if (voice_valid !== 4'b0000 && strobe_cycle == 0) begin
        strobe_cycle = k;
        strobe_valid = voice_valid;
        strobe_on    = voice_on;
      end
    end
    ready_at_end = event_ready;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (voice_valid !== 4'b0000) begin
      fails++; $display("FAIL reset_valid: got %b required 0000", voice_valid);
    end
    checks++;
    if (voice_busy !== 4'b0000) begin
      fails++; $display("FAIL reset_busy: got %b required 0000", voice_busy);
    end
    checks++;
    if (event_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: got %b required 1", event_ready);
    end
    checks++;
    if (voice_note !== '0 || voice_velocity !== '0) begin
      fails++; $display("FAIL reset_note_vel: got %h/%h required 0/0", voice_note, voice_velocity);
    end
  endtask

  task automatic test_first_note();
    apply_reset();
    send_event(1'b1, 7'd60, 7'd100);
    checks++;
    if (strobe_cycle !== 6) begin
      fails++; $display("FAIL first_latency: strobe cycle %0d required 6", strobe_cycle);
    end
    checks++;
    if (strobe_valid !== 4'b0001 || strobe_on !== 4'b0001) begin
      fails++;
      $display("FAIL first_strobe: valid=%b on=%b required 0001/0001", strobe_valid, strobe_on);
    end
    checks++;
    if (voice_note[0] !== 7'd60 || voice_velocity[0] !== 7'd100) begin
      fails++;
      $display("FAIL first_note_vel: got %0d/%0d required 60/100", voice_note[0],
               voice_velocity[0]);
    end
    checks++;
    if (voice_busy !== 4'b0001) begin
      fails++; $display("FAIL first_busy: got %b required 0001", voice_busy);
    end
    checks++;
    if (ready_at_end !== 1'b1) begin
      fails++; $display("FAIL first_ready: got %b required 1", ready_at_end);
    end
    @(negedge clock_50_000_000);
    checks++;
    if (voice_valid !== 4'b0000) begin
      fails++; $display("FAIL first_one_cycle: valid=%b required 0000", voice_valid);
    end
  endtask

  task automatic test_fill_and_steal();
    logic [6:0] notes[5] = '{7'd60, 7'd62, 7'd64, 7'd65, 7'd67};
    logic [3:0] exp_v[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    for (int n = 0; n < 5; n++) begin
      send_event(1'b1, notes[n], 7'd90);
      checks++;
      if (strobe_valid !== exp_v[n] || strobe_on !== exp_v[n]) begin
        fails++;
        $display("FAIL fill_target[%0d]: valid=%b on=%b required %b", n, strobe_valid,
                 strobe_on, exp_v[n]);
      end
    end
    checks++;
    if (voice_note[0] !== 7'd67 || voice_note[1] !== 7'd62 || voice_note[3] !== 7'd65) begin
      fails++;
      $display("FAIL steal_notes: got %0d,%0d,%0d required 67,62,65", voice_note[0],
               voice_note[1], voice_note[3]);
    end
    checks++;
    if (voice_busy !== 4'b1111) begin
      fails++; $display("FAIL steal_busy: got %b required 1111", voice_busy);
    end
  endtask

  task automatic test_velocity_zero();
    apply_reset();
    send_event(1'b1, 7'd60, 7'd100);
    send_event(1'b1, 7'd60, 7'd0);
    checks++;
    if (strobe_valid !== 4'b0001 || strobe_on !== 4'b0000) begin
      fails++;
      $display("FAIL vel0_strobe: valid=%b on=%b required 0001/0000", strobe_valid, strobe_on);
    end
    checks++;
    if (voice_busy !== 4'b0000) begin
      fails++; $display("FAIL vel0_busy: got %b required 0000", voice_busy);
    end
  endtask

  task automatic test_sustain();
    int         rel_cycle = 0;
    logic [3:0] rel_valid = '0;
    logic [3:0] rel_on    = '0;
    logic       ready_pending;
    apply_reset();
    send_event(1'b1, 7'd60, 7'd80);
    send_event(1'b1, 7'd62, 7'd80);
    send_event(1'b1, 7'd64, 7'd80);
    @(negedge clock_50_000_000);
    sustain = 1'b1;
    send_event(1'b0, 7'd60, 7'd0);
    checks++;
    if (strobe_cycle !== 0) begin
      fails++; $display("FAIL sus_off60: strobe at cycle %0d required none", strobe_cycle);
    end
    send_event(1'b0, 7'd62, 7'd0);
    checks++;
    if (strobe_cycle !== 0) begin
      fails++; $display("FAIL sus_off62: strobe at cycle %0d required none", strobe_cycle);
    end
    checks++;
    if (voice_busy !== 4'b0111) begin
      fails++; $display("FAIL sus_busy_held: got %b required 0111", voice_busy);
    end
    @(negedge clock_50_000_000);
    sustain = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock_50_000_000);
      if (k == 1) ready_pending = event_ready;
      if (voice_valid !== 4'b0000 && rel_cycle == 0) begin
        rel_cycle = k;
        rel_valid = voice_valid;
        rel_on    = voice_on;
      end
    end
    checks++;
    if (ready_pending !== 1'b0) begin
      fails++; $display("FAIL sus_ready_pending: got %b required 0", ready_pending);
    end
    checks++;
    if (rel_cycle !== 3 || rel_valid !== 4'b0011 || rel_on !== 4'b0000) begin
      fails++;
      $display("FAIL sus_release: cycle %0d valid=%b on=%b required 3/0011/0000", rel_cycle,
               rel_valid, rel_on);
    end
    checks++;
    if (voice_busy !== 4'b0100) begin
      fails++; $display("FAIL sus_busy_after: got %b required 0100", voice_busy);
    end
  endtask

  task automatic test_no_match();
    apply_reset();
    send_event(1'b1, 7'd60, 7'd100);
    send_event(1'b0, 7'd70, 7'd0);
    checks++;
    if (strobe_cycle !== 0) begin
      fails++; $display("FAIL nomatch_strobe: strobe at cycle %0d required none", strobe_cycle);
    end
    checks++;
    if (ready_at_end !== 1'b1) begin
      fails++; $display("FAIL nomatch_ready: got %b required 1", ready_at_end);
    end
    checks++;
    if (voice_busy !== 4'b0001) begin
      fails++; $display("FAIL nomatch_busy: got %b required 0001", voice_busy);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic seen = 1'b0;
    apply_reset();
    send_event(1'b1, 7'd60, 7'd100);
    @(negedge clock_50_000_000);
    event_valid    = 1'b1;
    event_on       = 1'b1;
    event_note     = 7'd62;
    event_velocity = 7'd50;
    @(posedge clock_50_000_000);
    #1 event_valid = 1'b0;
    repeat (2) @(negedge clock_50_000_000);
    reset_l = 1'b0;
    #1;
    checks++;
    if (voice_valid !== 4'b0000 || voice_busy !== 4'b0000) begin
      fails++;
      $display("FAIL midscan_outputs: valid=%b busy=%b required 0000/0000", voice_valid,
               voice_busy);
    end
    checks++;
    if (voice_note[0] !== 7'd0 || voice_velocity[0] !== 7'd0) begin
      fails++;
      $display("FAIL midscan_note_vel: got %0d/%0d required 0/0", voice_note[0],
               voice_velocity[0]);
    end
    @(negedge clock_50_000_000);
    reset_l = 1'b1;
    #1;
    checks++;
    if (event_ready !== 1'b1) begin
      fails++; $display("FAIL midscan_ready: got %b required 1", event_ready);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clock_50_000_000);
      if (voice_valid !== 4'b0000) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL midscan_no_strobe: strobe seen=%b required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_first_note();
    test_fill_and_steal();
    test_velocity_zero();
    test_sustain();
    test_no_match();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter PIPELINE_COUNT, default 4, SHALL set the number of synthesis voices managed; legal range 2..16.
REQ-002 Parameter AGE_WIDTH, default 8, SHALL set the width of each per-voice saturating age counter.
REQ-003 clock_50_000_000  in  1  system clock; all state updates on its rising edge.
REQ-004 reset_l  in  1  reset, asynchronous, active-low.
REQ-005 event_valid  in  1  note event offered.
REQ-006 event_ready  out  1  allocator can accept an event; transfer occurs when event_valid && event_ready.
REQ-007 event_on  in  1  1 = note-on, 0 = note-off.
REQ-008 event_note  in  7  MIDI note number.
REQ-009 event_velocity  in  7  MIDI velocity.
REQ-010 sustain  in  1  sustain pedal level; 1 = held.
REQ-011 voice_valid  out  PIPELINE_COUNT  one-cycle command strobe per voice.
REQ-012 voice_on  out  PIPELINE_COUNT  command type per voice; 1 = note-on, 0 = note-off; meaningful only with voice_valid.
REQ-013 voice_note  out  PIPELINE_COUNT x 7  note per voice, held until that voice's next command.
REQ-014 voice_velocity  out  PIPELINE_COUNT x 7  velocity per voice, held until that voice's next command.
REQ-015 voice_busy  out  PIPELINE_COUNT  1 = voice sounding or sustained.

Function
REQ-016 The FSM SHALL have states IDLE, SCAN, ISSUE and RELEASE.
REQ-017 event_ready SHALL be 1 only in IDLE when no sustain release is pending.
REQ-018 On acceptance, the event SHALL be captured, normalising note-on with velocity 0 to note-off; IDLE -> SCAN.
REQ-019 SCAN SHALL examine one voice per cycle, index 0 to PIPELINE_COUNT-1, recording:
- match: busy voice whose note equals the event note;
- first free voice;
- oldest busy voice: maximum age, ties to lowest index.
SCAN -> ISSUE after the last index.
REQ-020 ISSUE SHALL last exactly one cycle, then -> IDLE; an event accepted at edge T produces its strobe in the cycle after edge T+PIPELINE_COUNT+1.
REQ-021 Note-on target voice, in priority order: matching voice (retrigger), else lowest free voice, else oldest voice (steal).
REQ-022 For note-on, ISSUE SHALL:
- assert voice_valid and voice_on for the target only;
- load voice_note and voice_velocity;
- set busy, clear sustained, zero the target's age;
- increment every other busy voice's age, saturating at all-ones.
REQ-023 Note-off with a match and sustain=0: ISSUE SHALL strobe voice_valid with voice_on=0 for the match and clear its busy.
REQ-024 Note-off with a match and sustain=1: the match SHALL be marked sustained, remain busy, and no strobe is issued.
REQ-025 Note-off with no match SHALL be dropped; ISSUE occurs with all voice_valid = 0.
REQ-026 A falling edge of sustain (registered 1 -> 0) SHALL set a release-pending flag, serviced from IDLE via RELEASE.
REQ-027 RELEASE SHALL last one cycle: assert voice_valid with voice_on=0 on every sustained voice simultaneously, clear their busy and sustained flags, then -> IDLE.
REQ-028 If release is pending and event_valid=1 in IDLE, RELEASE SHALL go first and event_ready SHALL be 0 that cycle.
REQ-029 A sustain falling edge that arrives during SCAN/ISSUE SHALL remain pending until the next IDLE and SHALL NOT be lost.
REQ-030 voice_valid SHALL be 0 in every state other than ISSUE and RELEASE.

Reset
REQ-031 Assertion of reset_l SHALL, asynchronously and in any state including mid-SCAN, force:
- FSM to IDLE;
- all voice_valid, voice_on, voice_note, voice_velocity, voice_busy, sustained flags and ages to 0;
- release-pending and captured event cleared.
REQ-032 event_ready SHALL be 1 in the first cycle after reset_l deasserts.

Structure
REQ-033 The voice_command_t struct (valid, on, note, velocity) and the FSM state enum SHALL reside in the shared MIDI package.
REQ-034 The saturating per-voice age counter SHALL be a sub-module, voice_age_counter, instantiated PIPELINE_COUNT times.

Verification (PIPELINE_COUNT=4)
REQ-035 Note-on 60 vel 100 after reset -> voice 0 strobe on, note 60 / vel 100, exactly 6 cycles after acceptance; busy=0001.
REQ-036 Note-ons 60, 62, 64, 65, 67 -> voices 0-3 filled in order; 67 steals voice 0 (age 3, oldest); busy=1111.
REQ-037 Note-on 60 vel 0 while voice 0 holds 60 -> voice 0 strobe off; busy bit 0 cleared.
REQ-038 sustain=1, note-off 60 and 62 -> no strobes; sustain 1 -> 0 -> single-cycle strobe off on voices 0 and 1 together.
REQ-039 Note-off 70 with no matching voice -> no strobe; event_ready returns to 1 after 6 cycles.
REQ-040 reset_l pulsed low during SCAN -> all outputs 0 immediately; no strobe follows; event_ready=1 after release.
